// File: rtl/pwm_ramp_controller.sv
// PWM register file plus a duty-cycle ramp engine. Register writes and ramp steps land on the clk edge; status is registered.
// No backpressure: a write is accepted in any cycle, and an SPI duty write pre-empts the ramp.
module pwm_ramp_controller #(
    parameter int PRESC_SHIFT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_wr_valid,
    input  logic [6:0] spi_wr_addr,
    input  logic [7:0] spi_wr_data,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       ramp_busy,
    output logic       ramp_done
);

    localparam int PW = 9 + PRESC_SHIFT;

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_en_out_lo, r_en_out_hi, r_en_pwm_lo, r_en_pwm_hi;
    logic [7:0]    r_duty, r_ramp_target, r_ramp_step, r_ramp_interval;
    logic          r_bounce;
    logic [7:0]    r_act_target, r_origin, r_act_step;
    logic [PW-1:0] r_period_m1, r_presc;
    logic          r_done;

    logic [7:0]    w_duty_nxt, w_act_target_nxt, w_origin_nxt, w_act_step_nxt;
    logic [PW-1:0] w_period_m1_nxt, w_presc_nxt, w_period_m1;
    logic          w_done_nxt;
    logic          w_wr_ctrl, w_start, w_abort, w_duty_wr, w_step_due;
    logic [8:0]    w_sum, w_diff;
    logic [7:0]    w_step_val;

    assign w_wr_ctrl  = spi_wr_valid && (spi_wr_addr == 7'h08);
    assign w_abort    = w_wr_ctrl && spi_wr_data[2];
    assign w_start    = w_wr_ctrl && spi_wr_data[0] && !spi_wr_data[2];
    assign w_duty_wr  = spi_wr_valid && (spi_wr_addr == 7'h04);
    assign w_step_due = (r_presc == r_period_m1);

    assign w_period_m1 = ((PW'(r_ramp_interval) + PW'(1)) << PRESC_SHIFT) - PW'(1);

    // 9-bit arithmetic so the clamp to target sees overflow and underflow.
    assign w_sum  = {1'b0, r_duty} + {1'b0, r_act_step};
    assign w_diff = {1'b0, r_duty} - {1'b0, r_act_step};

    always_comb begin
        w_step_val = r_act_target;
        if (r_duty < r_act_target) begin
            if (w_sum < {1'b0, r_act_target})
                w_step_val = w_sum[7:0];
        end else if (!w_diff[8] && (w_diff[7:0] > r_act_target)) begin
            w_step_val = w_diff[7:0];
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_duty_nxt       = r_duty;
        w_act_target_nxt = r_act_target;
        w_origin_nxt     = r_origin;
        w_act_step_nxt   = r_act_step;
        w_period_m1_nxt  = r_period_m1;
        w_presc_nxt      = r_presc;
        w_done_nxt       = 1'b0;
        if (w_duty_wr) begin
            w_duty_nxt  = spi_wr_data;
            w_state_nxt = IDLE;
        end else if (w_abort) begin
            w_state_nxt = IDLE;
        end else if (w_start) begin
            w_act_target_nxt = r_ramp_target;
            w_origin_nxt     = r_duty;
            w_act_step_nxt   = (r_ramp_step == 8'd0) ? 8'd1 : r_ramp_step;
            w_period_m1_nxt  = w_period_m1;
            w_presc_nxt      = '0;
            if (r_duty == r_ramp_target) begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end else begin
                w_state_nxt = RUN;
            end
        end else if (r_state == RUN) begin
            if (w_step_due) begin
                w_presc_nxt = '0;
                w_duty_nxt  = w_step_val;
                if (w_step_val == r_act_target) begin
                    if (r_bounce) begin
                        w_act_target_nxt = r_origin;
                        w_origin_nxt     = r_act_target;
                    end else begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end else begin
                w_presc_nxt = r_presc + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_en_out_lo     <= '0;
            r_en_out_hi     <= '0;
            r_en_pwm_lo     <= '0;
            r_en_pwm_hi     <= '0;
            r_duty          <= '0;
            r_ramp_target   <= '0;
            r_ramp_step     <= '0;
            r_ramp_interval <= '0;
            r_bounce        <= 1'b0;
            r_act_target    <= '0;
            r_origin        <= '0;
            r_act_step      <= '0;
            r_period_m1     <= '0;
            r_presc         <= '0;
            r_done          <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_duty       <= w_duty_nxt;
            r_act_target <= w_act_target_nxt;
            r_origin     <= w_origin_nxt;
            r_act_step   <= w_act_step_nxt;
            r_period_m1  <= w_period_m1_nxt;
            r_presc      <= w_presc_nxt;
            r_done       <= w_done_nxt;
            if (spi_wr_valid) begin
                case (spi_wr_addr)
                    7'h00:   r_en_out_lo     <= spi_wr_data;
                    7'h01:   r_en_out_hi     <= spi_wr_data;
                    7'h02:   r_en_pwm_lo     <= spi_wr_data;
                    7'h03:   r_en_pwm_hi     <= spi_wr_data;
                    7'h05:   r_ramp_target   <= spi_wr_data;
                    7'h06:   r_ramp_step     <= spi_wr_data;
                    7'h07:   r_ramp_interval <= spi_wr_data;
                    7'h08:   r_bounce        <= spi_wr_data[1];
                    default: ;
                endcase
            end
        end
    end

    assign en_reg_out_7_0  = r_en_out_lo;
    assign en_reg_out_15_8 = r_en_out_hi;
    assign en_reg_pwm_7_0  = r_en_pwm_lo;
    assign en_reg_pwm_15_8 = r_en_pwm_hi;
    assign pwm_duty_cycle  = r_duty;
    assign ramp_busy       = (r_state == RUN);
    assign ramp_done       = r_done;

endmodule

// File: doc/pwm_ramp_controller.md
Name: pwm_ramp_controller

Overview:
Register file and ramp sequencer between the SPI write port and the PWM peripheral. It owns the five PWM configuration registers: output enables, PWM enables and duty cycle. Decoded SPI writes either load those registers directly or program a ramp engine. The ramp engine steps the duty-cycle register toward a target at a programmed rate, optionally bouncing between two endpoints. SPI writes and the ramp engine share the single duty register; SPI always wins.

Parameters:
PRESC_SHIFT, 8, step period = (interval+1) << PRESC_SHIFT clk cycles.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-high.
spi_wr_valid  input  1  one-cycle pulse; decoded SPI register write.
spi_wr_addr  input  7  register address.
spi_wr_data  input  8  write data.
en_reg_out_7_0  output  8  output enables, bits 7:0.
en_reg_out_15_8  output  8  output enables, bits 15:8.
en_reg_pwm_7_0  output  8  PWM enables, bits 7:0.
en_reg_pwm_15_8  output  8  PWM enables, bits 15:8.
pwm_duty_cycle  output  8  current duty cycle.
ramp_busy  output  1  ramp in progress.
ramp_done  output  1  one-cycle pulse when a non-bounce ramp reaches its target.

Behaviour:
- Reset (rst=1 at a clk edge), including mid-ramp:
  - all outputs and internal registers go to 0; state IDLE.
  - no done pulse is generated.
- Register map; all writes land at the clk edge where spi_wr_valid=1:
  - 0x00 en_reg_out_7_0, 0x01 en_reg_out_15_8, 0x02 en_reg_pwm_7_0, 0x03 en_reg_pwm_15_8, 0x04 pwm_duty_cycle.
  - 0x05 ramp_target.
  - 0x06 ramp_step; 0 is treated as 1.
  - 0x07 ramp_interval.
  - 0x08 control: bit0 start, bit1 bounce, bit2 abort. start and abort are self-clearing strobes; bounce is stored.
  - Other addresses are ignored, with no side effects.
- Ramp configuration: 0x05–0x07 written while RUN only update the stored value. The active target, step and period are latched at start and used from the next start.
- States: IDLE, RUN.
- IDLE + start:
  - latch active_target=ramp_target, origin=pwm_duty_cycle, active step and period; clear the prescaler.
  - If pwm_duty_cycle==ramp_target: stay IDLE and pulse ramp_done on the next cycle. This applies with or without bounce.
  - Otherwise go to RUN with ramp_busy=1 from the next cycle.
- RUN + start: restart. Relatch everything as above and clear the prescaler.
- RUN stepping:
  - The prescaler counts clk cycles. The duty update is visible exactly P=(interval+1)<<PRESC_SHIFT cycles after the start edge, then every P cycles.
  - Step up: duty<target gives duty=min(duty+step, target), computed 9-bit, so there is no wrap.
  - Step down: duty>target gives duty=max(duty-step, target), computed signed 9-bit, so there is no underflow.
- Target reached on a step edge:
  - Non-bounce: on the same edge go to IDLE, ramp_busy=0, ramp_done=1 for exactly one cycle.
  - Bounce: swap active_target and origin and continue in RUN; never done.
- Abort (bit2=1) in RUN: go to IDLE, ramp_busy=0, no done pulse, duty holds its current value.
- Start and abort in the same write: abort wins. In IDLE this is a no-op.
- SPI write to 0x04 in RUN:
  - the SPI data is loaded and the ramp aborts, with no done pulse.
  - This applies even if a ramp step falls on the same edge; the SPI value wins.
- Writes to 0x00–0x03 never disturb the ramp.
- ramp_done and start never assert ramp_busy in the same cycle as ramp_done.

Test Plan:
Tests use PRESC_SHIFT=0.
- Reset/decode: pulse rst, then check every output is 0. Write 0x00=0xA5, 0x03=0x3C, 0x7F=0xFF. Required: en_reg_out_7_0=0xA5, en_reg_pwm_15_8=0x3C, all other outputs 0.
- Ramp up:
  - Stimulus: duty=0x10, target=0x40, step=0x10, interval=3, start at edge N.
  - Required duty: 0x20@N+4, 0x30@N+8, 0x40@N+12.
  - Required status: ramp_busy 1 from N+1 to N+11; ramp_done=1 only in the cycle after edge N+12, busy=0 from that point.
- Saturation:
  - Up: duty=0xF0, target=0xFF, step=0x20 gives 0xFF after one step and done.
  - Down: duty=0x05, target=0x00, step=0x10 gives 0x00 after one step.
  - step=0: duty=0x00, target=0x02 gives 0x01, then 0x02.
- SPI override:
  - Stimulus: ramp 0x00→0x80, step 0x10, interval 0, running. Write 0x04=0x77 on an edge where a step is also due.
  - Required: duty=0x77, busy=0, no done pulse ever follows.
- Bounce:
  - Stimulus: duty=0x00, target=0x20, step=0x10, interval=0, bounce+start.
  - Required duty sequence: 0x10, 0x20, 0x10, 0x00, 0x10…, with busy held 1.
  - Then write control abort: duty freezes, busy=0, no done.
- Edge cases:
  - Start with duty==target=0x33: done pulses once, busy never 1.
  - Write 0x05=0x90 mid-ramp (target 0x40): the ramp still ends at 0x40; the next start ramps to 0x90.
  - rst mid-ramp: all outputs 0 and no done pulse.
